fpu_arbiter: RTL

- Shares one fpu instance between two requesters (port A, port B) using round-robin arbitration.
- Latches the granted operand pair and restarts the FPU from a clean state for each operation by holding its active-low reset.
- Waits a fixed, parameterised number of cycles, then captures the FPU result and status and returns them on a single response channel tagged with the requester ID.
- Sits between the FPU and its client logic; the FPU has no start/done handshake, so this block supplies the sequencing.

---
 rtl/fpu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin share of one FPU between two requesters.
// Clean FPU restart per operation, fixed-latency result capture.
//
// Ports:
//   clock100KHz, reset         clock, async active-high reset
//   req_a_* / req_b_*          request channels (valid/ready, operands)
//   rsp_*                      response channel (valid/ready, id, data, status)
//   fpu_op_a/b, fpu_rst_n      drive the FPU operands and its active-low reset
//   fpu_data, fpu_status       FPU outputs, sampled after FPU_LAT wait cycles
//   busy                       high whenever not idle
module fpu_arbiter #(
   parameter int FPU_LAT = 70,
   parameter int CNT_W   = $clog2(FPU_LAT + 1)
) (
   input  logic        clock100KHz,
   input  logic        reset,
   input  logic        req_a_valid,
   output logic        req_a_ready,
   input  logic [31:0] req_a_op_a,
   input  logic [31:0] req_a_op_b,
   input  logic        req_b_valid,
   output logic        req_b_ready,
   input  logic [31:0] req_b_op_a,
   input  logic [31:0] req_b_op_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_status,
   output logic [31:0] fpu_op_a,
   output logic [31:0] fpu_op_b,
   output logic        fpu_rst_n,
   input  logic [31:0] fpu_data,
   input  logic [3:0]  fpu_status,
   output logic        busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last_grant;
   logic             r_id;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_data;
   logic [3:0]       r_rsp_status;
   logic [31:0]      r_op_a;
   logic [31:0]      r_op_b;
   logic             r_fpu_rst_n;

   logic w_idle;
   logic w_sel;
   logic w_ready_a;
   logic w_ready_b;
   logic w_accept;

   // Readies are gated by reset so every output reads zero while it is held.
   assign w_idle = (r_state == S_IDLE) && !reset;

   // One valid port wins outright; on contention the port that did not
   // win last time is selected.
   assign w_sel = (req_a_valid && req_b_valid) ? ~r_last_grant : req_b_valid;

   assign w_ready_a = w_idle && req_a_valid && !w_sel;
   assign w_ready_b = w_idle && req_b_valid &&  w_sel;
   assign w_accept  = w_ready_a || w_ready_b;

   always_ff @(posedge clock100KHz or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_status <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_fpu_rst_n  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op_a       <= w_sel ? req_b_op_a : req_a_op_a;
                  r_op_b       <= w_sel ? req_b_op_b : req_a_op_b;
                  r_id         <= w_sel;
                  r_last_grant <= w_sel;
                  r_state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               // FPU saw stable operands with reset held; release it now.
               r_cnt       <= CNT_W'(FPU_LAT);
               r_fpu_rst_n <= 1'b1;
               r_state     <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_rsp_data   <= fpu_data;
                  r_rsp_status <= fpu_status;
                  r_rsp_valid  <= 1'b1;
                  r_fpu_rst_n  <= 1'b0;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_a_ready = w_ready_a;
   assign req_b_ready = w_ready_b;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_id;
   assign rsp_data    = r_rsp_data;
   assign rsp_status  = r_rsp_status;
   assign fpu_op_a    = r_op_a;
   assign fpu_op_b    = r_op_b;
   assign fpu_rst_n   = r_fpu_rst_n;
   assign busy        = (r_state != S_IDLE);

endmodule
